knn_cache_arbiter: RTL and testbench

KNN_CACHE_ARBITER -- requirements
Module: knn_cache_arbiter

---
 rtl/knn_cache_pkg.sv | 18 +
 rtl/knn_rr_arb2.sv | 23 ++
 rtl/knn_cache_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_knn_cache_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_cache_pkg.sv
// Shared definitions for the KNN cache arbiter.
// Holds the default widths for the cache port and the arbiter state encoding.
//   KNN_ADDR_W  : word address width (512 words)
//   KNN_DATA_W  : data width
//   KNN_BURST_W : burstcount width (bursts of up to 16 words)
package knn_cache_pkg;

  localparam int KNN_ADDR_W  = 9;
  localparam int KNN_DATA_W  = 32;
  localparam int KNN_BURST_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST_RD = 2'd1,
    ST_BURST_WR = 2'd2
  } knn_state_t;

endpackage

// File: rtl/knn_rr_arb2.sv
// Two-way round-robin grant selection.
// Ports:
//   req        : request vector, bit N = master N
//   last_grant : master granted most recently (0 or 1)
//   grant      : one-hot grant, all zero when nobody requests
module knn_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the master not granted last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/knn_cache_arbiter.sv
// Arbitrates the Nios (master 0) and the KNN engine (master 1) onto port A of
// the cache RAM. Each master issues Avalon-style burst requests; the winner owns
// the RAM until its burst is complete. Read data comes straight from the RAM
// with one cycle of latency.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   mN_*                : burst master N command/write-data inputs,
//                         waitrequest / readdata / readdatavalid outputs
//   ram_*               : single-port cache RAM command outputs, ram_readdata in
module knn_cache_arbiter
  import knn_cache_pkg::*;
#(
  parameter int ADDR_W  = KNN_ADDR_W,
  parameter int DATA_W  = KNN_DATA_W,
  parameter int BURST_W = KNN_BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [3:0]         m0_byteenable,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [3:0]         m1_byteenable,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [3:0]         ram_byteenable,
  output logic [DATA_W-1:0]  ram_writedata,
  output logic               ram_clken,
  input  logic [DATA_W-1:0]  ram_readdata
);

  localparam logic [BURST_W-1:0] ONE_BEAT = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  knn_state_t         state_r;
  knn_state_t         state_s;
  logic               owner_r;
  logic               last_grant_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [BURST_W-1:0] remaining_r;
  logic [1:0]         rdv_r;

  logic [1:0]         req_s;
  logic [1:0]         grant_s;
  logic               grant_any_s;
  logic               idle_grant_s;
  logic               src_s;
  logic [ADDR_W-1:0]  src_addr_s;
  logic               src_write_s;
  logic [3:0]         src_be_s;
  logic [DATA_W-1:0]  src_wd_s;
  logic [BURST_W-1:0] src_bc_s;
  logic [BURST_W-1:0] len_s;

  logic               issue_s;
  logic               issue_wr_s;
  logic [1:0]         accept_s;
  logic [ADDR_W-1:0]  beat_addr_s;

  // Either strobe counts as a request; write precedence is applied when the
  // granted master's command is decoded below
  assign req_s = {m1_read | m1_write, m0_read | m0_write};

  knn_rr_arb2 u_arb (
    .req        (req_s),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  assign grant_any_s  = |grant_s;
  assign idle_grant_s = (state_r == ST_IDLE) && grant_any_s;

  // In IDLE the command comes from the master being granted, otherwise from
  // the burst owner
  assign src_s       = (state_r == ST_IDLE) ? grant_s[1] : owner_r;
  assign src_addr_s  = src_s ? m1_address    : m0_address;
  assign src_write_s = src_s ? m1_write      : m0_write;
  assign src_be_s    = src_s ? m1_byteenable : m0_byteenable;
  assign src_wd_s    = src_s ? m1_writedata  : m0_writedata;
  assign src_bc_s    = src_s ? m1_burstcount : m0_burstcount;
  assign len_s       = (src_bc_s == {BURST_W{1'b0}}) ? ONE_BEAT : src_bc_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: single-beat transfers never leave IDLE, bursts return to
  // IDLE right after their last beat so a new grant can happen without a bubble
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s && (len_s != ONE_BEAT)) begin
          state_s = src_write_s ? ST_BURST_WR : ST_BURST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST_RD: begin
        if (remaining_r == ONE_BEAT) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BURST_RD;
        end
      end
      ST_BURST_WR: begin
        if (issue_s && (remaining_r == ONE_BEAT)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BURST_WR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: which beat goes to the RAM this cycle and which master, if
  // any, sees its command accepted. Everything is held quiet while in reset so
  // a master already requesting cannot slip a beat through.
  always_comb begin
    issue_s     = 1'b0;
    issue_wr_s  = 1'b0;
    accept_s    = 2'b00;
    beat_addr_s = {ADDR_W{1'b0}};
    if (!reset_n) begin
      issue_s  = 1'b0;
      accept_s = 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            accept_s    = grant_s;
            issue_s     = 1'b1;
            issue_wr_s  = src_write_s;
            beat_addr_s = src_addr_s;
          end else begin
            accept_s = 2'b00;
          end
        end
        ST_BURST_RD: begin
          issue_s     = 1'b1;
          beat_addr_s = addr_r;
        end
        ST_BURST_WR: begin
          // Only the owner's write strobe moves a write burst forward; a read
          // strobe from the owner is simply left waiting
          if (src_write_s) begin
            accept_s    = owner_r ? 2'b10 : 2'b01;
            issue_s     = 1'b1;
            issue_wr_s  = 1'b1;
            beat_addr_s = addr_r;
          end else begin
            issue_s = 1'b0;
          end
        end
        default: issue_s = 1'b0;
      endcase
    end
  end

  // Burst bookkeeping: owner, next beat address, beats left, round-robin
  // history, and the one-cycle read-valid pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      remaining_r  <= {BURST_W{1'b0}};
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      rdv_r        <= 2'b00;
    end else begin
      rdv_r <= (issue_s && !issue_wr_s) ? (src_s ? 2'b10 : 2'b01) : 2'b00;
      if (idle_grant_s) begin
        owner_r      <= grant_s[1];
        last_grant_r <= grant_s[1];
        addr_r       <= src_addr_s + ADDR_ONE;
        remaining_r  <= len_s - ONE_BEAT;
      end else if (issue_s) begin
        // address arithmetic wraps naturally at 2^ADDR_W
        addr_r      <= addr_r + ADDR_ONE;
        remaining_r <= remaining_r - ONE_BEAT;
      end
    end
  end

  assign ram_address      = beat_addr_s;
  assign ram_chipselect   = issue_s;
  assign ram_write        = issue_wr_s;
  assign ram_byteenable   = issue_s ? src_be_s : 4'b0000;
  assign ram_writedata    = src_wd_s;
  assign ram_clken        = 1'b1;

  assign m0_waitrequest   = ~accept_s[0];
  assign m1_waitrequest   = ~accept_s[1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rdv_r[0];
  assign m1_readdatavalid = rdv_r[1];

endmodule

// File: tb/tb_knn_cache_arbiter.sv
// Scoreboard bench for knn_cache_arbiter. Expected RAM beats and read data are
// computed per transaction from a word-array reference memory and queued; a
// monitor process pops and compares whenever the DUT issues a beat or a
// readdatavalid. A behavioural RAM with one cycle of read latency sits on the
// RAM port.
module tb_knn_cache_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
    logic [3:0]    be;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m_read [2];
  logic          m_write [2];
  logic [AW-1:0] m_addr [2];
  logic [3:0]    m_be [2];
  logic [DW-1:0] m_wd [2];
  logic [BW-1:0] m_bc [2];
  logic          m_wait [2];
  logic [DW-1:0] m_rdata [2];
  logic          m_rdv [2];
  logic [AW-1:0] ram_address;
  logic          ram_chipselect;
  logic          ram_write;
  logic [3:0]    ram_byteenable;
  logic [DW-1:0] ram_writedata;
  logic          ram_clken;
  logic [DW-1:0] ram_readdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc [2];

  logic [DW-1:0] mem [512];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] wd_buf [2][16];
  logic [3:0]    be_buf [2][16];
  beat_t         exp_beats [$];
  logic [DW-1:0] exp_rd0 [$];
  logic [DW-1:0] exp_rd1 [$];
  bit            loaded = 1'b0;

  knn_cache_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m_addr[0]),
    .m0_read          (m_read[0]),
    .m0_write         (m_write[0]),
    .m0_byteenable    (m_be[0]),
    .m0_writedata     (m_wd[0]),
    .m0_burstcount    (m_bc[0]),
    .m0_waitrequest   (m_wait[0]),
    .m0_readdata      (m_rdata[0]),
    .m0_readdatavalid (m_rdv[0]),
    .m1_address       (m_addr[1]),
    .m1_read          (m_read[1]),
    .m1_write         (m_write[1]),
    .m1_byteenable    (m_be[1]),
    .m1_writedata     (m_wd[1]),
    .m1_burstcount    (m_bc[1]),
    .m1_waitrequest   (m_wait[1]),
    .m1_readdata      (m_rdata[1]),
    .m1_readdatavalid (m_rdv[1]),
    .ram_address      (ram_address),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_byteenable   (ram_byteenable),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural cache RAM: byte-lane writes, registered read data
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int k = 0; k < 4; k++)
          if (ram_byteenable[k]) mem[ram_address][8*k +: 8] <= ram_writedata[8*k +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction of L words touches (a+i) mod 512
  task automatic expect_txn(input int m, input bit wr, input logic [AW-1:0] a, input int bc);
    int len;
    logic [AW-1:0] ad;
    logic [DW-1:0] mask;
    beat_t b;
    len = (bc == 0) ? 1 : bc;
    for (int i = 0; i < len; i++) begin
      ad = 9'((int'(a) + i) % 512);
      if (wr) begin
        for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{be_buf[m][i][k]}};
        ref_mem[ad] = (ref_mem[ad] & ~mask) | (wd_buf[m][i] & mask);
        b = '{addr: ad, wr: 1'b1, data: wd_buf[m][i], be: be_buf[m][i]};
      end else begin
        b = '{addr: ad, wr: 1'b0, data: 32'h0, be: 4'h0};
        if (m == 0) exp_rd0.push_back(ref_mem[ad]);
        else exp_rd1.push_back(ref_mem[ad]);
      end
      exp_beats.push_back(b);
    end
  endtask

  task automatic monitor_loop();
    beat_t b;
    forever begin
      @(negedge clk);
      if (ram_chipselect) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: chipselect 1 at address %0h, required no beat", ram_address);
        end else begin
          b = exp_beats.pop_front();
          check("beat_addr", 64'(ram_address), 64'(b.addr));
          check("beat_write", 64'(ram_write), 64'(b.wr));
          if (b.wr) begin
            check("beat_wdata", 64'(ram_writedata), 64'(b.data));
            check("beat_be", 64'(ram_byteenable), 64'(b.be));
          end
        end
      end
      if (m_rdv[0]) begin
        if (exp_rd0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdv_m0_unexpected: readdatavalid 1, required 0");
        end else check("rdata_m0", 64'(m_rdata[0]), 64'(exp_rd0.pop_front()));
      end
      if (m_rdv[1]) begin
        if (exp_rd1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdv_m1_unexpected: readdatavalid 1, required 0");
        end else check("rdata_m1", 64'(m_rdata[1]), 64'(exp_rd1.pop_front()));
      end
    end
  endtask

  task automatic wait_acc(input int m, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!m_wait[m]) begin
        ok = 1'b1;
        acc_cyc[m] = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_acc_m%0d: waitrequest still 1 after 64 cycles, required 0", m);
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one burst on master m; write beats may pause for gap_len cycles after
  // beat gap_at, and rd_too also raises read alongside write
  task automatic do_txn(input int m, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input int gap_at, input int gap_len, input bit rd_too);
    int len;
    bit ok;
    len = (bc == 0) ? 1 : int'(bc);
    m_addr[m] = a;
    m_bc[m]   = bc;
    if (!wr) begin
      m_read[m]  = 1'b1;
      m_write[m] = 1'b0;
      wait_acc(m, ok);
      m_read[m] = 1'b0;
    end else begin
      for (int i = 0; i < len; i++) begin
        m_wd[m]    = wd_buf[m][i];
        m_be[m]    = be_buf[m][i];
        m_write[m] = 1'b1;
        m_read[m]  = rd_too;
        wait_acc(m, ok);
        if (!ok) break;
        if (i == gap_at && i < len - 1 && gap_len > 0) begin
          m_write[m] = 1'b0;
          repeat (gap_len) @(posedge clk);
          #1;
        end
      end
      m_write[m] = 1'b0;
      m_read[m]  = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int start;
    int nmis;
    logic [AW-1:0] a;
    for (int m = 0; m < 2; m++) begin
      m_read[m] = 1'b0; m_write[m] = 1'b0; m_addr[m] = '0;
      m_be[m] = 4'hF; m_wd[m] = '0; m_bc[m] = '0;
      for (int i = 0; i < 16; i++) begin
        wd_buf[m][i] = 32'h0;
        be_buf[m][i] = 4'hF;
      end
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    fork
      monitor_loop();
    join_none

    // Reset state, with both masters already requesting
    reset_n = 1'b0;
    m_read[0] = 1'b1;
    m_read[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait_m0", 64'(m_wait[0]), 64'd1);
    check("rst_wait_m1", 64'(m_wait[1]), 64'd1);
    check("rst_cs", 64'(ram_chipselect), 64'd0);
    check("rst_write", 64'(ram_write), 64'd0);
    check("rst_addr", 64'(ram_address), 64'd0);
    check("rst_rdv_m0", 64'(m_rdv[0]), 64'd0);
    check("rst_rdv_m1", 64'(m_rdv[1]), 64'd0);
    check("clken", 64'(ram_clken), 64'd1);
    m_read[0] = 1'b0;
    m_read[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Tie right after reset: m0 first, m1 next; m0 re-requesting makes a second tie won by m1
    expect_txn(0, 1'b0, 9'h020, 1);
    expect_txn(1, 1'b0, 9'h130, 1);
    expect_txn(0, 1'b0, 9'h021, 1);
    start = cyc;
    fork
      begin
        do_txn(0, 1'b0, 9'h020, 5'd1, -1, 0, 1'b0);
        t0 = acc_cyc[0];
        do_txn(0, 1'b0, 9'h021, 5'd1, -1, 0, 1'b0);
      end
      begin
        do_txn(1, 1'b0, 9'h130, 5'd1, -1, 0, 1'b0);
      end
    join
    check("tie_m0_first", 64'(t0), 64'(start));
    check("tie_m1_next", 64'(acc_cyc[1]), 64'(start + 1));
    check("tie2_m0_after_m1", 64'(acc_cyc[0]), 64'(start + 2));
    repeat (3) @(posedge clk); #1;

    // m0 read burst of 4 from 0x010: beats on consecutive cycles, data one cycle later
    expect_txn(0, 1'b0, 9'h010, 4);
    do_txn(0, 1'b0, 9'h010, 5'd4, -1, 0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("rd4_cs", 64'(ram_chipselect), 64'd1);
      check("rd4_rdv", 64'(m_rdv[0]), 64'd1);
    end
    @(negedge clk);
    check("rd4_cs_end", 64'(ram_chipselect), 64'd0);
    check("rd4_rdv_last", 64'(m_rdv[0]), 64'd1);
    @(negedge clk);
    check("rd4_rdv_end", 64'(m_rdv[0]), 64'd0);
    @(posedge clk); #1;

    // m1 write burst wrapping past 0x1FF with a two-cycle pause after beat 1, then read back
    for (int i = 0; i < 16; i++) begin
      wd_buf[1][i] = $urandom;
      be_buf[1][i] = 4'hF;
    end
    expect_txn(1, 1'b1, 9'h1FE, 4);
    do_txn(1, 1'b1, 9'h1FE, 5'd4, 1, 2, 1'b0);
    expect_txn(0, 1'b0, 9'h1FE, 4);
    do_txn(0, 1'b0, 9'h1FE, 5'd4, -1, 0, 1'b0);
    repeat (5) @(posedge clk); #1;

    // m0 read burst of 8 while m1 requests: m1 held off until the cycle after the last beat
    expect_txn(0, 1'b0, 9'h0C4, 8);
    expect_txn(1, 1'b0, 9'h077, 1);
    fork
      do_txn(0, 1'b0, 9'h0C4, 5'd8, -1, 0, 1'b0);
      begin
        @(posedge clk); #1;
        do_txn(1, 1'b0, 9'h077, 5'd1, -1, 0, 1'b0);
      end
    join
    check("m1_after_burst8", 64'(acc_cyc[1]), 64'(acc_cyc[0] + 8));
    repeat (3) @(posedge clk); #1;

    // Reset after beat 2 of a 16-beat read: burst aborted, only beats 0..2 and data 0..1 seen
    a = 9'h0A0;
    expect_txn(0, 1'b0, a, 3);
    void'(exp_rd0.pop_back());
    do_txn(0, 1'b0, a, 5'd16, -1, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    m_read[0] = 1'b1;
    m_read[1] = 1'b1;
    @(negedge clk);
    check("rst2_wait_m0", 64'(m_wait[0]), 64'd1);
    check("rst2_wait_m1", 64'(m_wait[1]), 64'd1);
    check("rst2_cs", 64'(ram_chipselect), 64'd0);
    check("rst2_rdv_m0", 64'(m_rdv[0]), 64'd0);
    check("rst2_addr", 64'(ram_address), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    m_read[0] = 1'b0;
    m_read[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_txn(0, 1'b0, 9'h005, 1);
    start = cyc;
    do_txn(0, 1'b0, 9'h005, 5'd1, -1, 0, 1'b0);
    check("post_reset_idle_grant", 64'(acc_cyc[0]), 64'(start));
    repeat (3) @(posedge clk); #1;

    // Randomized mixed traffic, one transaction at a time
    for (int t = 0; t < 40; t++) begin
      int m;
      bit wr;
      logic [AW-1:0] ra;
      logic [BW-1:0] bc;
      m  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ra = 9'($urandom_range(0, 511));
      bc = 5'($urandom_range(0, 16));
      for (int i = 0; i < 16; i++) begin
        wd_buf[m][i] = $urandom;
        be_buf[m][i] = 4'($urandom_range(0, 15));
      end
      expect_txn(m, wr, ra, int'(bc));
      do_txn(m, wr, ra, bc, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end
    repeat (24) @(posedge clk); #1;

    check("beats_drained", 64'(exp_beats.size()), 64'd0);
    check("rdata_m0_drained", 64'(exp_rd0.size()), 64'd0);
    check("rdata_m1_drained", 64'(exp_rd1.size()), 64'd0);
    nmis = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("ram_contents", 64'(nmis), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
